// File: rtl/mux_4x1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1_pkg
// Description : Shared constants and types for the 4:1 registered mux.
//               NUM_LANES - number of data lanes
//               SEL_W     - width of the lane select
//               sel_t     - binary-encoded lane select type
// Revision    : 1.0 - initial release
// ============================================================================
package mux_4x1_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_4x1_pkg
`default_nettype wire

// File: rtl/mux_4x1_lane_sel.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1_lane_sel
// Description : Pure combinational 4:1 lane selector.
// Ports       : din  [in ] NUM_LANES*WIDTH packed lanes, lane 0 in the LSBs
//               sel  [in ] binary lane select (0..3)
//               dout [out] selected lane
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4x1_lane_sel
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [NUM_LANES*WIDTH-1:0] din,
    input  sel_t                       sel,
    output logic [WIDTH-1:0]           dout
);

    logic [WIDTH-1:0] w_lane [NUM_LANES];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign w_lane[k] = din[k*WIDTH +: WIDTH];
    end

    // Nested ternaries rather than a case statement: an unknown select bit
    // then yields X only where the candidate lanes actually disagree, and
    // every select code has a defined result.
    assign dout = sel[1] ? (sel[0] ? w_lane[3] : w_lane[2])
                         : (sel[0] ? w_lane[1] : w_lane[0]);

endmodule : mux_4x1_lane_sel
`default_nettype wire

// File: rtl/mux_4x1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1
// Description : 4:1 lane multiplexer with combinational and registered
//               outputs, plus optional registered even parity.
// Ports       : clk    [in ] clock, rising edge
//               rst_n  [in ] synchronous active-low reset (registers only)
//               din    [in ] four packed lanes, lane k = din[k*WIDTH +: WIDTH]
//               sel    [in ] binary lane select
//               dout   [out] combinational selected lane
//               dout_r [out] dout registered, 1-cycle latency
//               par_r  [out] XOR-reduction of dout, registered alongside
//                            dout_r (only with MUX_4X1_PARITY_EN defined)
// Config      : MUX_4X1_PARITY_EN - adds the par_r port and register.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4x1
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_LANES*WIDTH-1:0] din,
    input  sel_t                       sel,
    output logic [WIDTH-1:0]           dout,
`ifdef MUX_4X1_PARITY_EN
    output logic                       par_r,
`endif
    output logic [WIDTH-1:0]           dout_r
);

    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;

    mux_4x1_lane_sel #(
        .WIDTH (WIDTH)
    ) u_lane_sel (
        .din  (din),
        .sel  (sel),
        .dout (dout_d)
    );

    // dout is never touched by reset; only the registered copy is cleared.
    assign dout = dout_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_r = dout_q;

`ifdef MUX_4X1_PARITY_EN
    logic par_d;
    logic par_q;

    // Parity is taken from the same combinational value that dout_q loads,
    // so par_r always describes the current dout_r.
    assign par_d = ^dout_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_r = par_q;
`endif

endmodule : mux_4x1
`default_nettype wire

// File: tb/tb_mux_4x1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4x1
// Description : Directed self-checking bench for mux_4x1 (WIDTH=1 and
//               WIDTH=8 instances sharing clock and reset). Parity checks
//               are compiled in when MUX_4X1_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4x1;

    logic        clk;
    logic        rst_n;

    logic [3:0]  din1;
    logic [1:0]  sel1;
    logic        dout1;
    logic        dout_r1;

    logic [31:0] din8;
    logic [1:0]  sel8;
    logic [7:0]  dout8;
    logic [7:0]  dout_r8;

    int checks;
    int failures;

`ifdef MUX_4X1_PARITY_EN
    logic par_r1;
    logic par_r8;
`endif

    mux_4x1 #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din1),
        .sel    (sel1),
        .dout   (dout1),
`ifdef MUX_4X1_PARITY_EN
        .par_r  (par_r1),
`endif
        .dout_r (dout_r1)
    );

    mux_4x1 #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din8),
        .sel    (sel8),
        .dout   (dout8),
`ifdef MUX_4X1_PARITY_EN
        .par_r  (par_r8),
`endif
        .dout_r (dout_r8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] dv;
        logic       exp_prev;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        din1     = 4'b0000;
        sel1     = 2'b00;
        din8     = 32'h0;
        sel8     = 2'b00;

        // Reset state
        tick();
        tick();
        check("rst_dout_r1", 32'(dout_r1), 32'h0);
        check("rst_dout_r8", 32'(dout_r8), 32'h0);
`ifdef MUX_4X1_PARITY_EN
        check("rst_par_r8", 32'(par_r8), 32'h0);
`endif

        // Purely combinational selection, no clock edge in between
        rst_n = 1'b1;
        din1  = 4'b0110;
        sel1 = 2'b00; #1; check("comb_sel0", 32'(dout1), 32'h0);
        sel1 = 2'b01; #1; check("comb_sel1", 32'(dout1), 32'h1);
        sel1 = 2'b10; #1; check("comb_sel2", 32'(dout1), 32'h1);
        sel1 = 2'b11; #1; check("comb_sel3", 32'(dout1), 32'h0);

        // Exhaustive sweep: each sel visited twice per din value
        tick();
        exp_prev = 1'b0;  // din=0110, sel=11 was loaded at that edge
        check("sweep_init_r", 32'(dout_r1), 32'h0);
        for (int d = 0; d < 16; d++) begin
            for (int s = 0; s < 8; s++) begin
                dv   = 4'(d);
                din1 = dv;
                sel1 = 2'(s);
                #1;
                check("sweep_dout", 32'(dout1), 32'(dv[2'(s)]));
                exp_prev = dv[2'(s)];
                tick();
                check("sweep_dout_r", 32'(dout_r1), 32'(exp_prev));
            end
        end

        // Reset held for two edges: dout keeps following din/sel
        din1  = 4'b1111;
        sel1  = 2'b10;
        rst_n = 1'b0;
        #1;
        check("rst_mid_dout", 32'(dout1), 32'h1);
        tick();
        check("rst_e1_dout", 32'(dout1), 32'h1);
        check("rst_e1_dout_r", 32'(dout_r1), 32'h0);
        tick();
        check("rst_e2_dout", 32'(dout1), 32'h1);
        check("rst_e2_dout_r", 32'(dout_r1), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_rel_dout_r", 32'(dout_r1), 32'h0);
        tick();
        check("rst_post_dout_r", 32'(dout_r1), 32'h1);

        // Same-cycle change of sel and din
        din1 = 4'b0001;
        sel1 = 2'b00;
        tick();
        check("same_pre_r", 32'(dout_r1), 32'h1);
        din1 = 4'b1000;
        sel1 = 2'b11;
        #1;
        check("same_dout", 32'(dout1), 32'h1);
        tick();
        check("same_dout_r", 32'(dout_r1), 32'h1);

        // WIDTH=8 lane select and parity
        din8 = 32'hDDCCBBAA;
        sel8 = 2'b10;
        #1;
        check("w8_dout_cc", 32'(dout8), 32'hCC);
        tick();
        check("w8_dout_r_cc", 32'(dout_r8), 32'hCC);
`ifdef MUX_4X1_PARITY_EN
        check("w8_par_cc", 32'(par_r8), 32'h0);
`endif
        sel8 = 2'b01; #1; check("w8_dout_bb", 32'(dout8), 32'hBB);
        sel8 = 2'b11; #1; check("w8_dout_dd", 32'(dout8), 32'hDD);
        sel8 = 2'b00; #1; check("w8_dout_aa", 32'(dout8), 32'hAA);

        din8 = 32'h00000001;
        sel8 = 2'b00;
        tick();
        check("w8_dout_r_01", 32'(dout_r8), 32'h01);
`ifdef MUX_4X1_PARITY_EN
        check("w8_par_01", 32'(par_r8), 32'h1);
`endif

        // Reset asserted between edges acts only at the next edge
        rst_n = 1'b0;
        #1;
        check("w8_rst_wait_r", 32'(dout_r8), 32'h01);
`ifdef MUX_4X1_PARITY_EN
        check("w8_rst_wait_par", 32'(par_r8), 32'h1);
`endif
        tick();
        check("w8_rst_dout_r", 32'(dout_r8), 32'h00);
        check("w8_rst_dout", 32'(dout8), 32'h01);
`ifdef MUX_4X1_PARITY_EN
        check("w8_rst_par", 32'(par_r8), 32'h0);
`endif
        rst_n = 1'b1;
        tick();
        check("w8_rel_dout_r", 32'(dout_r8), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_4x1
`default_nettype wire
